board_scanner: RTL
==================

Name: board_scanner

Overview:
- Downstream consumer of the generation engine's 256-bit board output (16x16, cell index = row*16 + col).
- Double-buffers accepted boards and multiplexes them onto an LED matrix one row at a time.
- Per row: shifts the column bits serially into an external column shift register, pulses latch, then enables that row for a dwell period.
- New boards are swapped in only at frame boundaries, so no frame ever shows mixed generations.

Parameters:
- ROWS, 16, number of matrix rows (board width is ROWS*COLS)
- COLS, 16, columns per row (bits shifted per row)
- CLK_DIV, 2, clk cycles per sclk half-period (>=1)
- DWELL, 1024, clk cycles each row stays enabled (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- board_in  in  ROWS*COLS  board from the generation engine; bit 16r+c = cell (r,c)
- board_valid  in  1  board_in valid this cycle
- board_ready  out  1  pending buffer empty; transfer occurs when valid&&ready
- sclk  out  1  column shift clock
- sdata  out  1  column serial data, valid from before each sclk rising edge
- latch  out  1  one-cycle pulse that transfers shifted bits to column drivers
- row_en  out  ROWS  one-hot row enable, active only during dwell
- frame_done  out  1  one-cycle pulse at each frame boundary (swap point)
- live_count  out  9  live cells in the active frame (only with the optional feature)

Behaviour:
- Reset state (async, reset=0): FSM=IDLE; row_en=0, sclk=0, sdata=0, latch=0, frame_done=0, board_ready=1, live_count=0; pending and active buffers cleared.
- Buffers:
  - pending (plus pending_full flag) and active.
  - Accept: board_valid && board_ready loads pending and sets pending_full. board_ready = !pending_full.
- FSM states: IDLE, LOAD, SHIFT, LATCH, DWELL.
- IDLE:
  - Outputs quiet. Leaves IDLE the cycle after pending_full is set.
  - On leaving: active <= pending, pending_full cleared, frame_done pulses, row=0, state -> LOAD.
- LOAD (1 cycle):
  - Column shift register <= active row bits [16r+15:16r].
  - sdata presents col 15 (MSB first).
- SHIFT (COLS*2*CLK_DIV cycles):
  - sclk low CLK_DIV cycles, then high CLK_DIV cycles, per bit.
  - sdata changes only while sclk is low, at the start of each low phase.
  - After the 16th high phase: sclk=0, state -> LATCH.
- LATCH (1 cycle): latch=1; row_en stays 0.
- DWELL (DWELL cycles): row_en = one-hot(row). At the end, row_en=0 and:
  - If row < ROWS-1: row++, state -> LOAD.
  - If row == ROWS-1 (frame boundary): row=0; if pending_full, swap as in IDLE and pulse frame_done; otherwise keep the same active frame with no frame_done pulse. State -> LOAD.
- Row period = 2 + 32*CLK_DIV + DWELL cycles; 1090 at defaults.
- Timing and boundary rules:
  - Swap decision uses the registered pending_full. A board accepted in the boundary cycle itself is swapped at the next boundary.
  - While pending is full, board_ready=0; the engine must hold board_in/board_valid.
  - row_en is never nonzero during LOAD, SHIFT or LATCH (anti-ghosting).
  - Reset mid-row: all outputs return to reset values immediately (async); both buffers are discarded.

Optional Feature:
- Macro BOARD_SCANNER_LIVE_COUNT_EN.
- Defined:
  - During SHIFT, each bit shifted out is accumulated. At the frame-boundary end of DWELL for row ROWS-1, live_count <= accumulated count for the frame just displayed, then the accumulator clears.
  - Range 0..256, hence 9 bits.
- Undefined: live_count is tied to 0 and the accumulator logic is absent.

Decomposition:
- Shared package: FSM state encoding, BOARD_W = ROWS*COLS, cell index function idx(r,c) = r*COLS + c; shared with the generation engine.
- One natural sub-module, col_shifter: loads 16 bits, generates sclk/sdata with CLK_DIV timing, returns a done pulse. The top level holds the buffers, the row FSM and the dwell counter.

Test Plan:
- Reset then idle, no valid: all outputs at reset values for 5000 cycles, board_ready=1, FSM in IDLE.
- Accept board with only cell (0,0) set (bit 0): frame_done pulses once. Row 0 shifts 15 zeros then a 1. row_en=16'h0001 for exactly 1024 cycles, starting 66 cycles after LOAD.
- Glider board (bits 1, 18, 32, 33, 34): per row, the 16 captured sdata bits on sclk rising edges equal the row slice. Latch pulses 16 times per frame; frame period is 17440 cycles.
- Second board offered mid-frame: accepted, board_ready=0 until the boundary. At the boundary, swap occurs and frame_done pulses. A third board held valid is stalled until then.
- Assert reset during SHIFT of row 7: row_en, sclk, sdata and latch go to 0 within the same cycle. After release the FSM sits in IDLE with board_ready=1 until a new board is accepted.
- With BOARD_SCANNER_LIVE_COUNT_EN: all-ones board gives live_count=256 after the first frame. Then an all-zero board gives 0 one frame after it is swapped in.

Source files
------------

// File: rtl/board_scanner_pkg.sv
// Shared board geometry, scanner FSM encoding and cell indexing.
// Used by the generation engine and the LED board scanner.
package board_scanner_pkg;

    localparam int BOARD_ROWS = 16;
    localparam int BOARD_COLS = 16;
    localparam int BOARD_W    = BOARD_ROWS * BOARD_COLS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DWELL = 3'd4;

    function automatic int idx(input int r, input int c);
        return r * BOARD_COLS + c;
    endfunction

endpackage

// File: rtl/board_scanner_col_shifter.sv
// Serialises one row MSB-first onto sclk/sdata, CLK_DIV cycles per
// sclk half-period; done_o marks the last high phase.
module board_scanner_col_shifter #(
    parameter int COLS    = 16,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [COLS-1:0] data_i,
    output logic            sclk_o,
    output logic            sdata_o,
    output logic            shift_o,
    output logic            done_o
);

    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW  = (COLS > 1) ? $clog2(COLS) : 1;

    logic            busy_q, busy_d;
    logic            phase_q, phase_d;
    logic [DVW-1:0]  div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [COLS-1:0] sh_q, sh_d;
    logic            last_div;

    assign last_div = (div_q == DVW'(CLK_DIV - 1));
    assign shift_o  = busy_q && phase_q && last_div;
    assign done_o   = shift_o && (bit_q == BW'(COLS - 1));
    assign sclk_o   = busy_q && phase_q;
    // MSB is visible during the load cycle, before the first rising edge
    assign sdata_o  = load_i ? data_i[COLS-1] : sh_q[COLS-1];

    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        if (load_i) begin
            sh_d    = data_i;
            busy_d  = 1'b1;
            phase_d = 1'b0;
            div_d   = '0;
            bit_d   = '0;
        end else if (busy_q) begin
            if (last_div) begin
                div_d   = '0;
                phase_d = !phase_q;
                if (phase_q) begin
                    sh_d  = {sh_q[COLS-2:0], 1'b0};
                    bit_d = bit_q + 1'b1;
                    if (done_o) begin
                        busy_d = 1'b0;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: rtl/board_scanner.sv
// Double-buffered LED matrix row scanner for generation-engine boards.
// Define BOARD_SCANNER_LIVE_COUNT_EN to add a per-frame live cell count.
module board_scanner
    import board_scanner_pkg::*;
#(
    parameter int ROWS    = BOARD_ROWS,
    parameter int COLS    = BOARD_COLS,
    parameter int CLK_DIV = 2,
    parameter int DWELL   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] board_in,
    input  logic                 board_valid,
    output logic                 board_ready,
    output logic                 sclk,
    output logic                 sdata,
    output logic                 latch,
    output logic [ROWS-1:0]      row_en,
    output logic                 frame_done,
    output logic [8:0]           live_count
);

    localparam int W   = ROWS * COLS;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [2:0]      state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DWW-1:0]  dwell_q, dwell_d;
    logic [W-1:0]    act_q, act_d;
    logic [W-1:0]    pend_q, pend_d;
    logic            full_q, full_d;
    logic            fd_q, fd_d;
    logic            load_w, swap_w;
    logic            dwell_end, last_row, frame_end;
    logic            sh_shift, sh_done;
    logic [COLS-1:0] row_bits;

    assign dwell_end = (state_q == S_DWELL)
                    && (dwell_q == DWW'(DWELL - 1));
    assign last_row  = (row_q == RW'(ROWS - 1));
    assign frame_end = dwell_end && last_row;
    assign row_bits  = act_q[int'(row_q)*COLS +: COLS];

    assign board_ready = !full_q;
    assign latch       = (state_q == S_LATCH);
    assign frame_done  = fd_q;
    // Rows are only driven during dwell so shifting never ghosts
    assign row_en = (state_q == S_DWELL)
                  ? (ROWS'(1) << row_q) : '0;

    board_scanner_col_shifter #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_w),
        .data_i  (row_bits),
        .sclk_o  (sclk),
        .sdata_o (sdata),
        .shift_o (sh_shift),
        .done_o  (sh_done)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        act_d   = act_q;
        pend_d  = pend_q;
        full_d  = full_q;
        fd_d    = 1'b0;
        load_w  = 1'b0;
        swap_w  = 1'b0;
        if (board_valid && !full_q) begin
            pend_d = board_in;
            full_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                swap_w = full_q;
            end
            S_LOAD: begin
                load_w  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (sh_done) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                dwell_d = '0;
                state_d = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_end) begin
                    dwell_d = '0;
                    state_d = S_LOAD;
                    if (last_row) begin
                        row_d  = '0;
                        swap_w = full_q;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Swaps only happen between frames, never mid-frame
        if (swap_w) begin
            act_d   = pend_q;
            full_d  = 1'b0;
            fd_d    = 1'b1;
            row_d   = '0;
            state_d = S_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            dwell_q <= '0;
            act_q   <= '0;
            pend_q  <= '0;
            full_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            fd_q    <= fd_d;
        end
    end

`ifdef BOARD_SCANNER_LIVE_COUNT_EN
    logic [8:0] acc_q, acc_d;
    logic [8:0] live_q, live_d;

    always_comb begin
        acc_d  = acc_q;
        live_d = live_q;
        if (frame_end) begin
            live_d = acc_q;
            acc_d  = '0;
        end else if (sh_shift) begin
            acc_d = acc_q + {8'd0, sdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            live_q <= '0;
        end else begin
            acc_q  <= acc_d;
            live_q <= live_d;
        end
    end

    assign live_count = live_q;
`else
    logic unused_shift;
    assign unused_shift = sh_shift;
    assign live_count   = '0;
`endif

endmodule
